// File: rtl/alu_share_ctrl_if.sv
// Request/response bundle between requesters and the shared-ALU controller.
// master = requester side, slave = controller side.
interface alu_share_ctrl_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ*SEL_W-1:0]  req_sel;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_zero;
  logic                      rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_sel, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result,
    input  rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_sel, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result,
    output rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one combinational ALU, one op in flight.
// Optional ALU_OPCODE_CHECK_EN: illegal selects answered with rsp_err.
module alu_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 4,
  parameter int ID_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  alu_share_ctrl_if.slave   bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   grant;
  logic              any_req;
  logic              accept;
  logic              illegal;
  logic              no_result;
  logic [DATA_W-1:0] grant_a;
  logic [DATA_W-1:0] grant_b;
  logic [SEL_W-1:0]  grant_sel;
  logic [ID_W-1:0]   rsp_id_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_zero_q;

  assign accept = (state == IDLE) && any_req;
  assign busy   = (state != IDLE);

  assign bus.rsp_valid  = (state == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;

  // beq and jump leave the ALU result undriven
  assign no_result = (alu_sel == SEL_W'(4'b1011)) ||
                     (alu_sel == SEL_W'(4'b1111));

  // round-robin pick: first valid after last_grant, wrapping
  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    any_req = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ)
        idx = idx - NUM_REQ;
      if (!any_req && bus.req_valid[idx[ID_W-1:0]]) begin
        any_req = 1'b1;
        grant   = idx[ID_W-1:0];
      end
    end
  end

  // select the granted requester's fields and one-hot ready
  always_comb begin
    grant_a       = '0;
    grant_b       = '0;
    grant_sel     = '0;
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == ID_W'(i)) begin
        grant_a   = bus.req_a[i*DATA_W +: DATA_W];
        grant_b   = bus.req_b[i*DATA_W +: DATA_W];
        grant_sel = bus.req_sel[i*SEL_W +: SEL_W];
        bus.req_ready[i] = accept;
      end
    end
  end

`ifdef ALU_OPCODE_CHECK_EN
  function automatic logic sel_legal(input logic [SEL_W-1:0] s);
    logic ok;
    ok = 1'b0;
    case (s)
      SEL_W'(4'b0001), SEL_W'(4'b0011),
      SEL_W'(4'b0100), SEL_W'(4'b1000),
      SEL_W'(4'b1100), SEL_W'(4'b1011),
      SEL_W'(4'b1111): ok = 1'b1;
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic err_q;

  assign illegal     = !sel_legal(grant_sel);
  assign bus.rsp_err = err_q;

  // error flag captured at accept, held through RESP
  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if (accept)
      err_q <= illegal;
  end
`else
  assign illegal     = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  // next state: illegal ops skip EXEC
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (any_req)
          state_nxt = illegal ? RESP : EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (bus.rsp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state, grant pointer, operand and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= ID_W'(NUM_REQ - 1);
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_sel      <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rsp_id_q   <= grant;
        last_grant <= grant;
        if (illegal) begin
          rsp_result_q <= '0;
          rsp_zero_q   <= 1'b0;
        end else begin
          alu_a   <= grant_a;
          alu_b   <= grant_b;
          alu_sel <= grant_sel;
        end
      end
      if (state == EXEC) begin
        rsp_result_q <= no_result ? '0 : alu_result;
        rsp_zero_q   <= alu_zero;
      end
    end
  end

endmodule
